// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard controller: frame FSM states,
// special scan codes and the set-2 scan code to ASCII translation.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Returns 0x00 for codes with no printable/control mapping.
    // Letters are translated to lower case first; shift only affects letters.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] lc;
        case (code)
            8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;
            8'h23: lc = 8'h64;  8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;
            8'h34: lc = 8'h67;  8'h33: lc = 8'h68;  8'h43: lc = 8'h69;
            8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
            8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;
            8'h4D: lc = 8'h70;  8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;
            8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;  8'h3C: lc = 8'h75;
            8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
            8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
            8'h45: lc = 8'h30;  8'h16: lc = 8'h31;  8'h1E: lc = 8'h32;
            8'h26: lc = 8'h33;  8'h25: lc = 8'h34;  8'h2E: lc = 8'h35;
            8'h36: lc = 8'h36;  8'h3D: lc = 8'h37;  8'h3E: lc = 8'h38;
            8'h46: lc = 8'h39;
            8'h29: lc = 8'h20;  8'h41: lc = 8'h2C;  8'h49: lc = 8'h2E;
            8'h4A: lc = 8'h2F;  8'h5A: lc = 8'h0D;  8'h66: lc = 8'h08;
            default: lc = 8'h00;
        endcase
        if (shift && lc >= 8'h61 && lc <= 8'h7A)
            return lc - 8'h20;
        return lc;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the keyboard clock/data, detects falling
// edges of the keyboard clock and assembles 11-bit frames.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   ps2_clk, ps2_dat    raw keyboard lines (asynchronous)
//   byte_done           one-cycle pulse after the stop-bit edge
//   byte_ok             frame passed odd parity and stop-bit check (valid with byte_done)
//   byte_data           received byte (valid with byte_done)
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (data low on a falling edge)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking the stop bit, then back to idle
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_done,
    output logic       byte_ok,
    output logic [7:0] byte_data
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          fall;
    logic          din;
    frame_state_t  state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tmr;

    // Two flops synchronize; the third only remembers the previous level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 3'b111;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    assign fall = clk_sync[2] & ~clk_sync[1];
    assign din  = dat_sync[1];

    // The timeout is a down-counter reloaded on every keyboard edge; reaching
    // zero outside idle abandons the partial frame silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            par       <= 1'b0;
            tmr       <= '0;
            byte_done <= 1'b0;
            byte_ok   <= 1'b0;
            byte_data <= 8'h00;
        end else begin
            byte_done <= 1'b0;
            if (fall) begin
                tmr <= TMR_LOAD;
                case (state)
                    ST_IDLE: begin
                        if (!din) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {din, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par   <= din;
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        byte_done <= 1'b1;
                        byte_ok   <= din & (^{shreg, par});
                        byte_data <= shreg;
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                if (tmr == '0) begin
                    state   <= ST_IDLE;
                    bit_cnt <= 3'd0;
                end else begin
                    tmr <= tmr - TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard controller: receives frames, decodes set-2 scan codes
// (break/extended prefixes, shift tracking) and queues ASCII keys in a
// first-word fall-through FIFO with sticky error flags.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   PS2_CLK, PS2_DAT    raw keyboard lines (asynchronous)
//   rd_en               pop the FIFO head (ignored when empty)
//   clr_err             clear parity_err and overflow
//   key_valid           FIFO non-empty
//   key_data            ASCII at the FIFO head, 0x00 when empty
//   parity_err          sticky: a frame failed parity or stop-bit check
//   overflow            sticky: a key was dropped on a full FIFO
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic       key_valid,
    output logic [7:0] key_data,
    output logic       parity_err,
    output logic       overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic          rx_done;
    logic          rx_ok;
    logic [7:0]    rx_data;
    logic          break_pending;
    logic          ext_pending;
    logic          shift;
    logic          is_prefix;
    logic          is_shift_code;
    logic [7:0]    ascii;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_ok;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (PS2_CLK),
        .ps2_dat   (PS2_DAT),
        .byte_done (rx_done),
        .byte_ok   (rx_ok),
        .byte_data (rx_data)
    );

    assign is_prefix     = (rx_data == SC_BREAK) || (rx_data == SC_EXT);
    assign is_shift_code = (rx_data == SC_LSHIFT) || (rx_data == SC_RSHIFT);
    assign ascii         = scan_to_ascii(rx_data, shift);

    // Extended keys are not translated at all, so they never push or touch shift.
    assign push = rx_done && rx_ok && !is_prefix && !ext_pending && !break_pending
                  && !is_shift_code && (ascii != 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            shift         <= 1'b0;
        end else if (rx_done && rx_ok) begin
            if (rx_data == SC_BREAK) begin
                break_pending <= 1'b1;
            end else if (rx_data == SC_EXT) begin
                ext_pending <= 1'b1;
            end else begin
                if (!ext_pending && is_shift_code)
                    shift <= !break_pending;
                break_pending <= 1'b0;
                ext_pending   <= 1'b0;
            end
        end
    end

    // A pop only ever removes an entry already present, so a write in the
    // same cycle is never consumed; a full FIFO accepts a push only alongside a pop.
    assign pop   = rd_en && (count != '0);
    assign full  = (count == CW'(FIFO_DEPTH));
    assign wr_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= ascii;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({wr_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (rx_done && !rx_ok)
                parity_err <= 1'b1;
            else if (clr_err)
                parity_err <= 1'b0;
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
        end
    end

    assign key_valid = (count != '0);
    assign key_data  = key_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: drives keyboard frames, keeps a byte-level model of
// the key queue and flags, and compares it with the DUT on every cycle.
module tb_ps2_key_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 200;
    localparam int H     = 8;     // half period of the keyboard clock in clk cycles

    localparam logic [7:0] LETTER_SC [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGIT_SC [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic       key_valid;
    logic [7:0] key_data;
    logic       parity_err;
    logic       overflow;

    ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .rd_en      (rd_en),
        .clr_err    (clr_err),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .parity_err (parity_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit run_chk = 1'b0;

    typedef struct {
        int         due;
        logic [7:0] code;
        bit         good;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] mq[$];
    bit         m_perr, m_ovf, m_brk, m_ext, m_shift;
    bit         m_pop, m_push, m_full, m_pset, m_oset;
    logic [7:0] m_a;
    ev_t        m_ev;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_ascii(input logic [7:0] sc, input bit sh);
        for (int i = 0; i < 26; i++)
            if (LETTER_SC[i] == sc) return (sh ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (DIGIT_SC[i] == sc) return 8'h30 + 8'(i);
        case (sc)
            8'h29:   return 8'h20;
            8'h41:   return 8'h2C;
            8'h49:   return 8'h2E;
            8'h4A:   return 8'h2F;
            8'h5A:   return 8'h0D;
            8'h66:   return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] sc, input bit good,
                              output bit push, output logic [7:0] a, output bit perr);
        push = 1'b0;
        a    = 8'h00;
        perr = 1'b0;
        if (!good) perr = 1'b1;
        else if (sc == 8'hF0) m_brk = 1'b1;
        else if (sc == 8'hE0) m_ext = 1'b1;
        else begin
            if (!m_ext) begin
                if (sc == 8'h12 || sc == 8'h59) m_shift = !m_brk;
                else if (!m_brk) begin
                    a    = ref_ascii(sc, m_shift);
                    push = (a != 8'h00);
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    // Model state advances on the same rising edges as the DUT registers.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            mq.delete();
            ev_q.delete();
            m_perr = 0; m_ovf = 0; m_brk = 0; m_ext = 0; m_shift = 0;
        end else begin
            m_pop  = rd_en && (mq.size() != 0);
            m_push = 1'b0;
            m_pset = 1'b0;
            m_a    = 8'h00;
            if (ev_q.size() != 0 && ev_q[0].due == cyc) begin
                m_ev = ev_q.pop_front();
                model_byte(m_ev.code, m_ev.good, m_push, m_a, m_pset);
            end
            m_full = (mq.size() == DEPTH);
            m_oset = m_push && m_full && !m_pop;
            if (m_pop) void'(mq.pop_front());
            if (m_push && (!m_full || m_pop)) mq.push_back(m_a);
            m_perr = m_pset ? 1'b1 : (clr_err ? 1'b0 : m_perr);
            m_ovf  = m_oset ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
        end
    end

    always @(negedge clk) begin
        if (rst_n && run_chk) begin
            check("key_valid", key_valid, mq.size() != 0);
            check("key_data", key_data, (mq.size() != 0) ? mq[0] : 8'h00);
            check("parity_err", parity_err, m_perr);
            check("overflow", overflow, m_ovf);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling clk edge; the keyboard changes data H cycles
    // before its falling clock edge, as a real device does.
    task automatic ps2_bit(input logic b, input bit last, input logic [7:0] code,
                           input bit good, input bit rdp, input bit chk_lat);
        ev_t e;
        PS2_DAT = b;
        repeat (H) @(negedge clk);
        PS2_CLK = 1'b0;
        if (last) begin
            e.due  = cyc + 4;
            e.code = code;
            e.good = good;
            ev_q.push_back(e);
        end
        for (int j = 1; j <= H; j++) begin
            @(negedge clk);
            if (last && rdp && j == 3) rd_en = 1'b1;
            if (last && rdp && j == 4) rd_en = 1'b0;
            if (last && chk_lat && j == 3) check("latency_c3_kv", key_valid, 8'h00);
            if (last && chk_lat && j == 4) check("latency_c4_kv", key_valid, 8'h01);
        end
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad, input bit rdp, input bit chk_lat);
        logic [10:0] f;
        f = {1'b1, (~^code) ^ bad, code, 1'b0};
        for (int i = 0; i < 11; i++)
            ps2_bit(f[i], i == 10, code, !bad, rdp, chk_lat);
        PS2_DAT = 1'b1;
        idle(2 * H);
    endtask

    task automatic key(input logic [7:0] code);
        send_frame(code, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic partial(input int nbits);
        ps2_bit(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++)
            ps2_bit(i[0], 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        PS2_DAT = 1'b1;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        check({name, "_valid"}, key_valid, 8'h01);
        check(name, key_data, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check("rst_key_valid", key_valid, 8'h00);
        check("rst_key_data", key_data, 8'h00);
        check("rst_parity_err", parity_err, 8'h00);
        check("rst_overflow", overflow, 8'h00);
        rst_n   = 1'b1;
        run_chk = 1'b1;
        idle(4);

        // make 'a', break 'a': one entry, key_valid two cycles after detection
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
        key(8'hF0); key(8'h1C);
        pop_expect("t1_a", 8'h61);
        check("t1_empty", key_valid, 8'h00);

        // shifted letter then unshifted after shift release
        key(8'h12); key(8'h1C); key(8'hF0); key(8'h1C);
        key(8'hF0); key(8'h12); key(8'h1C);
        pop_expect("t2_A", 8'h41);
        pop_expect("t2_a", 8'h61);
        check("t2_empty", key_valid, 8'h00);

        // read while empty is ignored
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0; @(negedge clk);
        check("t3_empty_rd", key_valid, 8'h00);

        // bad parity: no push, sticky error, clearable
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        check("t4_perr_set", parity_err, 8'h01);
        check("t4_no_push", key_valid, 8'h00);
        pulse_clr();
        check("t4_perr_clr", parity_err, 8'h00);
        key(8'h1C);
        pop_expect("t4_a", 8'h61);

        // overflow: a..e into a 4-deep FIFO, then 'f' with a pop in its push cycle
        key(8'h1C); key(8'h32); key(8'h21); key(8'h23); key(8'h24);
        check("t5_ovf_set", overflow, 8'h01);
        check("t5_head", key_data, 8'h61);
        send_frame(8'h2B, 1'b0, 1'b1, 1'b0);
        check("t5_ovf_hold", overflow, 8'h01);
        pop_expect("t5_b", 8'h62);
        pop_expect("t5_c", 8'h63);
        pop_expect("t5_d", 8'h64);
        pop_expect("t5_f", 8'h66);
        check("t5_empty", key_valid, 8'h00);
        pulse_clr();
        check("t5_ovf_clr", overflow, 8'h00);

        // partial frame abandoned by timeout; scan code 0x16 is the '1' key
        partial(3);
        idle(TMO);
        key(8'h16);
        check("t6_perr", parity_err, 8'h00);
        check("t6_ovf", overflow, 8'h00);
        pop_expect("t6_1", 8'h31);
        check("t6_empty", key_valid, 8'h00);

        // extended key discarded; reset mid-frame clears queue and shift
        key(8'h12); key(8'h1C); key(8'hE0); key(8'h75);
        pop_expect("t7_A", 8'h41);
        check("t7_ext_dropped", key_valid, 8'h00);
        key(8'h32);
        partial(4);
        rst_n = 1'b0;
        idle(3);
        check("t7_rst_kv", key_valid, 8'h00);
        check("t7_rst_kd", key_data, 8'h00);
        rst_n = 1'b1;
        idle(4);
        key(8'h1C);
        pop_expect("t7_a", 8'h61);
        check("t7_empty", key_valid, 8'h00);

        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
